board_state_ctl: RTL and testbench

- Parametrised game-board controller for one player's grid.
- Stores a 2-bit status per cell and runs a command FSM for ship placement and shot resolution.
- Keeps deploy and remaining-ship counters, and exposes an independent registered read port for the grid renderer.
- Sits between the game-flow control FSM and the grid drawing pipeline; it replaces fixed-size board handling.

---
 rtl/board_state_ctl.sv | 205 ++++++++++++++++++++
 tb/tb_board_state_ctl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_state_ctl.sv
// Single-player game-board controller: per-cell status store, place/shot command FSM,
// ship counters and a registered renderer read port. BOARD_SHOT_STATS_EN adds shot/hit counters.
module board_state_ctl #(
    parameter int unsigned GRID_W       = 10,
    parameter int unsigned GRID_H       = 10,
    parameter int unsigned SHIPS_NUMBER = 10,
    parameter int unsigned XW           = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    parameter int unsigned YW           = (GRID_H > 1) ? $clog2(GRID_H) : 1,
    parameter int unsigned CW           = $clog2(SHIPS_NUMBER + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_op_i,
    input  logic [XW-1:0] cmd_x_i,
    input  logic [YW-1:0] cmd_y_i,
    output logic          rsp_valid_o,
    output logic          rsp_ok_o,
    output logic [1:0]    rsp_status_o,
    input  logic [XW-1:0] rd_x_i,
    input  logic [YW-1:0] rd_y_i,
    output logic [1:0]    rd_status_o,
    output logic [CW-1:0] ships_placed_o,
    output logic [CW-1:0] ships_left_o,
    output logic          deploy_done_o,
    output logic          all_sunk_o
`ifdef BOARD_SHOT_STATS_EN
    ,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0] shot_cnt_o,
    output logic [$clog2(GRID_W*GRID_H+1)-1:0] hit_cnt_o
`endif
);

    localparam int unsigned N  = GRID_W * GRID_H;
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ShipsMax = CW'(SHIPS_NUMBER);

    localparam logic [1:0] CellEmpty = 2'b00;
    localparam logic [1:0] CellShip  = 2'b01;

    typedef enum logic [1:0] {StClear, StIdle, StRead, StExec} state_e;

    logic [1:0]    mem_q [N];
    state_e        state_q;
    logic [AW-1:0] clr_addr_q;
    logic          op_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic          rsp_ok_q;
    logic [1:0]    rsp_status_q;
    logic [1:0]    rd_status_q;
    logic [CW-1:0] ships_placed_q;
    logic [CW-1:0] ships_left_q;

    logic          cmd_in_range;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cur_cell;
    logic          rd_in_range;
    logic [AW-1:0] rd_addr;
    logic          deploy_done;
    logic          apply;
    logic [1:0]    new_cell;
    logic [1:0]    rsp_status_d;

`ifdef BOARD_SHOT_STATS_EN
    localparam int unsigned SW = $clog2(N + 1);
    localparam logic [SW-1:0] StatMax = SW'(N);
    logic [SW-1:0] shot_cnt_q;
    logic [SW-1:0] hit_cnt_q;
`endif

    function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return AW'(32'(y) * GRID_W + 32'(x));
    endfunction

    always_comb begin
        cmd_in_range = (32'(x_q) < GRID_W) && (32'(y_q) < GRID_H);
        cmd_addr     = cell_addr(x_q, y_q);
        cur_cell     = cmd_in_range ? mem_q[cmd_addr] : CellEmpty;
        rd_in_range  = (32'(rd_x_i) < GRID_W) && (32'(rd_y_i) < GRID_H);
        rd_addr      = cell_addr(rd_x_i, rd_y_i);
        deploy_done  = (ships_placed_q == ShipsMax);
        apply        = 1'b0;
        new_cell     = CellShip;
        if (!op_q) begin
            apply    = cmd_in_range && !deploy_done && (cur_cell == CellEmpty);
            new_cell = CellShip;
        end else begin
            // EMPTY -> MISS, MYSHIP -> HIT; MISS/HIT are already resolved.
            apply    = cmd_in_range && deploy_done && !cur_cell[1];
            new_cell = {1'b1, cur_cell[0]};
        end
        rsp_status_d = apply ? new_cell : cur_cell;
    end

    // Decision and cell write commit on the READ->EXEC edge so the response is visible in EXEC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StClear;
            clr_addr_q     <= '0;
            op_q           <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_ok_q       <= 1'b0;
            rsp_status_q   <= CellEmpty;
            rd_status_q    <= CellEmpty;
            ships_placed_q <= '0;
            ships_left_q   <= '0;
`ifdef BOARD_SHOT_STATS_EN
            shot_cnt_q     <= '0;
            hit_cnt_q      <= '0;
`endif
        end else begin
            rd_status_q <= rd_in_range ? mem_q[rd_addr] : CellEmpty;
            rsp_valid_q <= 1'b0;
            if (clear_i) begin
                state_q        <= StClear;
                clr_addr_q     <= '0;
                cmd_ready_q    <= 1'b0;
                ships_placed_q <= '0;
                ships_left_q   <= '0;
`ifdef BOARD_SHOT_STATS_EN
                shot_cnt_q     <= '0;
                hit_cnt_q      <= '0;
`endif
            end else begin
                unique case (state_q)
                    StClear: begin
                        mem_q[clr_addr_q] <= CellEmpty;
                        if (clr_addr_q == AW'(N - 1)) begin
                            state_q     <= StIdle;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            clr_addr_q <= clr_addr_q + AW'(1);
                        end
                    end
                    StIdle: begin
                        if (cmd_valid_i && cmd_ready_q) begin
                            op_q        <= cmd_op_i;
                            x_q         <= cmd_x_i;
                            y_q         <= cmd_y_i;
                            cmd_ready_q <= 1'b0;
                            state_q     <= StRead;
                        end
                    end
                    StRead: begin
                        rsp_valid_q  <= 1'b1;
                        rsp_ok_q     <= apply;
                        rsp_status_q <= rsp_status_d;
                        if (apply) begin
                            mem_q[cmd_addr] <= new_cell;
                            if (!op_q) begin
                                ships_placed_q <= ships_placed_q + CW'(1);
                                if (ships_left_q != ShipsMax) begin
                                    ships_left_q <= ships_left_q + CW'(1);
                                end
                            end else if (cur_cell == CellShip && ships_left_q != '0) begin
                                ships_left_q <= ships_left_q - CW'(1);
                            end
`ifdef BOARD_SHOT_STATS_EN
                            if (op_q) begin
                                if (shot_cnt_q != StatMax) begin
                                    shot_cnt_q <= shot_cnt_q + SW'(1);
                                end
                                if (cur_cell == CellShip && hit_cnt_q != StatMax) begin
                                    hit_cnt_q <= hit_cnt_q + SW'(1);
                                end
                            end
`endif
                        end
                        state_q <= StExec;
                    end
                    StExec: begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                    default: begin
                        state_q <= StClear;
                    end
                endcase
            end
        end
    end

    assign cmd_ready_o    = cmd_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_ok_o       = rsp_ok_q;
    assign rsp_status_o   = rsp_status_q;
    assign rd_status_o    = rd_status_q;
    assign ships_placed_o = ships_placed_q;
    assign ships_left_o   = ships_left_q;
    assign deploy_done_o  = deploy_done;
    assign all_sunk_o     = deploy_done && (ships_left_q == '0);
`ifdef BOARD_SHOT_STATS_EN
    assign shot_cnt_o     = shot_cnt_q;
    assign hit_cnt_o      = hit_cnt_q;
`endif

endmodule

// File: tb/tb_board_state_ctl.sv
// Directed bench for board_state_ctl on the default 10x10 board with 10 ships; expected
// responses go through a scoreboard queue and are popped when rsp_valid fires.
module tb_board_state_ctl;

    localparam int XW = 4;
    localparam int YW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [XW-1:0] cmd_x;
    logic [YW-1:0] cmd_y;
    logic          rsp_valid;
    logic          rsp_ok;
    logic [1:0]    rsp_status;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [1:0]    rd_status;
    logic [CW-1:0] ships_placed;
    logic [CW-1:0] ships_left;
    logic          deploy_done;
    logic          all_sunk;
`ifdef BOARD_SHOT_STATS_EN
    logic [6:0]    shot_cnt;
    logic [6:0]    hit_cnt;
`endif

    typedef struct packed {
        logic       ok;
        logic [1:0] st;
    } rsp_t;

    rsp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [1:0] rd_at_rsp;

    always #5 clk = ~clk;

    board_state_ctl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_x_i        (cmd_x),
        .cmd_y_i        (cmd_y),
        .rsp_valid_o    (rsp_valid),
        .rsp_ok_o       (rsp_ok),
        .rsp_status_o   (rsp_status),
        .rd_x_i         (rd_x),
        .rd_y_i         (rd_y),
        .rd_status_o    (rd_status),
        .ships_placed_o (ships_placed),
        .ships_left_o   (ships_left),
        .deploy_done_o  (deploy_done),
        .all_sunk_o     (all_sunk)
`ifdef BOARD_SHOT_STATS_EN
        ,
        .shot_cnt_o     (shot_cnt),
        .hit_cnt_o      (hit_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until cmd_ready rises; no response may appear meanwhile.
    task automatic wait_ready(input string tag, input int exp_cycles);
        int   n = 0;
        logic seen_rsp = 1'b0;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_norsp"}, 32'(seen_rsp), 32'(0));
    endtask

    task automatic read_cell(input string tag, input int x, input int y, input logic [1:0] exp);
        rd_x = XW'(x);
        rd_y = YW'(y);
        tick();
        check(tag, 32'(rd_status), 32'(exp));
    endtask

    task automatic do_cmd(input logic op, input int x, input int y, input logic eok,
                          input logic [1:0] est);
        int   n = 0;
        int   lat = 0;
        rsp_t exp;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_ready", 32'(cmd_ready), 32'(1));
        sb.push_back('{ok: eok, st: est});
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = XW'(x);
        cmd_y     = YW'(y);
        tick();
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(1));
        if (rsp_valid && sb.size() > 0) begin
            exp = sb.pop_front();
            check("rsp_ok", 32'(rsp_ok), 32'(exp.ok));
            check("rsp_status", 32'(rsp_status), 32'(exp.st));
            rd_at_rsp = rd_status;
        end
        tick();
        check("rsp_pulse", 32'(rsp_valid), 32'(0));
        check("ready_again", 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int   n;
        logic seen;
        rst = 1'b1; clear = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_x = '0; cmd_y = '0; rd_x = '0; rd_y = '0; rd_at_rsp = 2'b00;

        // Reset state and initial sweep
        repeat (3) tick();
        check("rst_ready", 32'(cmd_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_ok", 32'(rsp_ok), 32'(0));
        check("rst_rsp_status", 32'(rsp_status), 32'(0));
        check("rst_rd_status", 32'(rd_status), 32'(0));
        check("rst_placed", 32'(ships_placed), 32'(0));
        check("rst_left", 32'(ships_left), 32'(0));
        check("rst_deploy", 32'(deploy_done), 32'(0));
        rst = 1'b0;
        wait_ready("reset", 100);
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                read_cell("rd_cleared", x, y, 2'b00);

        // Place and repeat place; aliasing out-of-range coordinates
        do_cmd(1'b0, 3, 4, 1'b1, 2'b01);
        check("placed_1", 32'(ships_placed), 32'(1));
        check("left_1", 32'(ships_left), 32'(1));
        do_cmd(1'b0, 3, 4, 1'b0, 2'b01);
        check("placed_dup", 32'(ships_placed), 32'(1));
        read_cell("rd_34", 3, 4, 2'b01);
        read_cell("rd_oor", 13, 3, 2'b00);
        do_cmd(1'b0, 13, 3, 1'b0, 2'b00);
        check("placed_oor", 32'(ships_placed), 32'(1));

        // Shot before deploy_done
        do_cmd(1'b1, 0, 0, 1'b0, 2'b00);
        read_cell("rd_00_early", 0, 0, 2'b00);

        // Clear aborts an in-flight command; clear during sweep restarts it
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_x = 4'd5; cmd_y = 4'd5;
        tick();
        cmd_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_rsp", 32'(rsp_valid), 32'(0));
        check("abort_placed", 32'(ships_placed), 32'(0));
        check("abort_left", 32'(ships_left), 32'(0));
        seen = 1'b0;
        n = 0;
        repeat (40) begin
            tick();
            if (rsp_valid || cmd_ready) seen = 1'b1;
            n++;
        end
        check("sweep_quiet", 32'(seen), 32'(0));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_ready("reclear", 100);
        read_cell("rd_55_aborted", 5, 5, 2'b00);
        read_cell("rd_34_cleared", 3, 4, 2'b00);

        // Full deploy, then a rejected 11th ship
        for (int i = 0; i < 10; i++) begin
            do_cmd(1'b0, i, 0, 1'b1, 2'b01);
            check("placed_n", 32'(ships_placed), 32'(i + 1));
            check("deploy_done_n", 32'(deploy_done), 32'(i == 9));
        end
        do_cmd(1'b0, 0, 1, 1'b0, 2'b00);
        check("placed_sat", 32'(ships_placed), 32'(10));
        check("left_full", 32'(ships_left), 32'(10));

        // Shots: hit, repeat, miss with same-cycle read, sink the rest
        do_cmd(1'b1, 0, 0, 1'b1, 2'b11);
        check("left_9", 32'(ships_left), 32'(9));
        do_cmd(1'b1, 0, 0, 1'b0, 2'b11);
        check("left_repeat", 32'(ships_left), 32'(9));
        rd_x = 4'd0; rd_y = 4'd5;
        tick();
        do_cmd(1'b1, 0, 5, 1'b1, 2'b10);
        check("rd_old_value", 32'(rd_at_rsp), 32'(0));
        check("rd_new_value", 32'(rd_status), 32'(2));
        for (int i = 1; i < 10; i++) begin
            do_cmd(1'b1, i, 0, 1'b1, 2'b11);
            check("all_sunk_n", 32'(all_sunk), 32'(i == 9));
        end
        check("left_0", 32'(ships_left), 32'(0));
`ifdef BOARD_SHOT_STATS_EN
        check("shot_cnt", 32'(shot_cnt), 32'(11));
        check("hit_cnt", 32'(hit_cnt), 32'(10));
`endif
        do_cmd(1'b1, 5, 0, 1'b0, 2'b11);
        check("left_no_wrap", 32'(ships_left), 32'(0));
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
